// File: rtl/pse_pkg.sv
// Shared types and default geometry for the pattern scan engine.
package pse_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LD_PAT = 3'd1,
        SCAN   = 3'd2,
        WR_CTB = 3'd3,
        WR_CTO = 3'd4,
        WR_CTS = 3'd5,
        DONE   = 3'd6
    } pse_state_t;

    localparam int DEF_PAT_W     = 5;
    localparam int DEF_MSG_BYTES = 32;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_CNT_W     = 8;
    localparam int DEF_MSG_BASE  = 0;
    localparam int DEF_PAT_ADDR  = 32;
    localparam int DEF_RES_ADDR  = 33;

    // Within-byte plus crossing matches never exceed 8, so 4 bits suffice.
    localparam int INC_W = 4;

    function automatic int windows_per_byte(input int pat_w);
        return 9 - pat_w;
    endfunction

endpackage

// File: rtl/window_match_unit.sv
// Counts pattern hits in one message byte and in the windows straddling the
// boundary with the previous byte (bit 7 is the earliest bit of a byte).
module window_match_unit
    import pse_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W
) (
    input  logic [PAT_W-2:0] prev,
    input  logic [7:0]       cur,
    input  logic [PAT_W-1:0] pat,
    input  logic             first,
    output logic [INC_W-1:0] in_cnt,
    output logic [INC_W-1:0] cross_cnt,
    output logic             any_in
);

    localparam int N_IN  = windows_per_byte(PAT_W);
    localparam int CAT_W = PAT_W + 7;

    logic [CAT_W-1:0] cat;

    assign cat = {prev, cur};

    always_comb begin
        in_cnt    = '0;
        cross_cnt = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (cur[k +: PAT_W] == pat) begin
                in_cnt = in_cnt + INC_W'(1);
            end
        end
        // Windows starting above N_IN-1 pull their leading bits from prev.
        for (int k = N_IN; k < 8; k++) begin
            if (!first && (cat[k +: PAT_W] == pat)) begin
                cross_cnt = cross_cnt + INC_W'(1);
            end
        end
    end

    assign any_in = (in_cnt != '0);

endmodule

// File: rtl/pattern_scan_engine.sv
// Bit-pattern counting accelerator sharing the single data-memory port:
// loads pattern and message, then writes ctb/cto/cts result bytes.
//
// state  | meaning
// IDLE   | waiting for start, memory port quiet
// LD_PAT | reading pattern byte at PAT_ADDR
// SCAN   | reading message byte idx and accumulating counts
// WR_CTB | writing within-byte match count
// WR_CTO | writing count of bytes with any match
// WR_CTS | writing whole-string match count
// DONE   | results committed, done held until next start
module pattern_scan_engine
    import pse_pkg::*;
#(
    parameter int PAT_W     = DEF_PAT_W,
    parameter int MSG_BYTES = DEF_MSG_BYTES,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int MSG_BASE  = DEF_MSG_BASE,
    parameter int PAT_ADDR  = DEF_PAT_ADDR,
    parameter int RES_ADDR  = DEF_RES_ADDR
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic              done
);

    localparam int SUM_W = CNT_W + INC_W;

    pse_state_t         state;
    logic [PAT_W-1:0]   pat;
    logic [PAT_W-2:0]   prev;
    logic [ADDR_W-1:0]  idx;
    logic [CNT_W-1:0]   ctb;
    logic [CNT_W-1:0]   cto;
    logic [CNT_W-1:0]   cts;

    logic [INC_W-1:0]   in_cnt;
    logic [INC_W-1:0]   cross_cnt;
    logic [INC_W-1:0]   total_inc;
    logic               any_in;
    logic               first;
    logic               last;
    logic [7:0]         ctb_byte;
    logic [7:0]         cto_byte;
    logic [7:0]         cts_byte;

    // Increment is widened before the add so a large step cannot wrap.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [INC_W-1:0] inc);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(inc);
        if (s[SUM_W-1:CNT_W] != '0) begin
            return '1;
        end
        return s[CNT_W-1:0];
    endfunction

    assign first     = (idx == '0);
    assign last      = (idx == ADDR_W'(MSG_BYTES - 1));
    assign total_inc = in_cnt + cross_cnt;

    window_match_unit #(
        .PAT_W (PAT_W)
    ) u_match (
        .prev      (prev),
        .cur       (mem_rdata),
        .pat       (pat),
        .first     (first),
        .in_cnt    (in_cnt),
        .cross_cnt (cross_cnt),
        .any_in    (any_in)
    );

    generate
        if (CNT_W >= 8) begin : g_res_trunc
            assign ctb_byte = ctb[7:0];
            assign cto_byte = cto[7:0];
            assign cts_byte = cts[7:0];
        end else begin : g_res_pad
            assign ctb_byte = {{(8 - CNT_W){1'b0}}, ctb};
            assign cto_byte = {{(8 - CNT_W){1'b0}}, cto};
            assign cts_byte = {{(8 - CNT_W){1'b0}}, cts};
        end
    endgenerate

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            pat   <= '0;
            prev  <= '0;
            idx   <= '0;
            ctb   <= '0;
            cto   <= '0;
            cts   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= LD_PAT;
                        ctb   <= '0;
                        cto   <= '0;
                        cts   <= '0;
                    end
                end
                LD_PAT: begin
                    pat   <= mem_rdata[7:8-PAT_W];
                    idx   <= '0;
                    state <= SCAN;
                end
                SCAN: begin
                    ctb  <= sat_add(ctb, in_cnt);
                    cto  <= sat_add(cto, INC_W'(any_in));
                    cts  <= sat_add(cts, total_inc);
                    prev <= mem_rdata[PAT_W-2:0];
                    idx  <= idx + ADDR_W'(1);
                    if (last) begin
                        state <= WR_CTB;
                    end
                end
                WR_CTB:  state <= WR_CTO;
                WR_CTO:  state <= WR_CTS;
                WR_CTS:  state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    // Port outputs decode straight from state so an async reset silences them at once.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        case (state)
            LD_PAT: mem_addr = ADDR_W'(PAT_ADDR);
            SCAN:   mem_addr = ADDR_W'(MSG_BASE) + idx;
            WR_CTB: begin
                mem_addr  = ADDR_W'(RES_ADDR);
                mem_wdata = ctb_byte;
                mem_we    = 1'b1;
            end
            WR_CTO: begin
                mem_addr  = ADDR_W'(RES_ADDR + 1);
                mem_wdata = cto_byte;
                mem_we    = 1'b1;
            end
            WR_CTS: begin
                mem_addr  = ADDR_W'(RES_ADDR + 2);
                mem_wdata = cts_byte;
                mem_we    = 1'b1;
            end
            default: begin
                mem_addr  = '0;
                mem_wdata = '0;
                mem_we    = 1'b0;
            end
        endcase
    end

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_pattern_scan_engine.sv
// Directed bench: default 32-byte engine plus a 64-byte engine for saturation.
module tb_pattern_scan_engine;

    logic       clk;
    logic       rst;
    logic       start_a;
    logic       start_b;
    logic [7:0] addr_a, rdata_a, wdata_a;
    logic [7:0] addr_b, rdata_b, wdata_b;
    logic       we_a, busy_a, done_a;
    logic       we_b, busy_b, done_b;
    logic [7:0] mem_a [0:255];
    logic [7:0] mem_b [0:255];

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pattern_scan_engine u_dut_a (
        .CLK       (clk),
        .Reset     (rst),
        .start     (start_a),
        .mem_addr  (addr_a),
        .mem_rdata (rdata_a),
        .mem_wdata (wdata_a),
        .mem_we    (we_a),
        .busy      (busy_a),
        .done      (done_a)
    );

    pattern_scan_engine #(
        .MSG_BYTES (64),
        .PAT_ADDR  (64),
        .RES_ADDR  (65)
    ) u_dut_b (
        .CLK       (clk),
        .Reset     (rst),
        .start     (start_b),
        .mem_addr  (addr_b),
        .mem_rdata (rdata_b),
        .mem_wdata (wdata_b),
        .mem_we    (we_b),
        .busy      (busy_b),
        .done      (done_b)
    );

    assign rdata_a = mem_a[addr_a];
    assign rdata_b = mem_b[addr_b];

    always @(posedge clk) begin
        if (we_a) mem_a[addr_a] = wdata_a;
        if (we_b) mem_b[addr_b] = wdata_b;
    end

    task automatic fill_a(input logic [7:0] pat_byte, input logic [7:0] fill);
        for (int i = 0; i < 32; i++) mem_a[i] = fill;
        mem_a[32] = pat_byte;
    endtask

    task automatic do_run(input bit use_b, input int pulse_at,
                          output int cycles, output int busy_cycles, output logic done_at0);
        @(negedge clk);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        done_at0    = use_b ? done_b : done_a;
        busy_cycles = (use_b ? busy_b : busy_a) ? 1 : 0;
        cycles      = 0;
        while (!(use_b ? done_b : done_a) && cycles < 200) begin
            if (cycles == pulse_at) begin
                if (use_b) start_b = 1'b1; else start_a = 1'b1;
            end
            @(posedge clk);
            #1;
            start_a = 1'b0;
            start_b = 1'b0;
            cycles++;
            if (use_b ? busy_b : busy_a) busy_cycles++;
        end
    endtask

    task automatic test_reset();
        checks++; if (busy_a !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        checks++; if (done_a !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b want 0", done_a); end
        checks++; if (we_a !== 1'b0)    begin errors++; $display("FAIL reset_we: got %b want 0", we_a); end
        checks++; if (addr_a !== 8'd0)  begin errors++; $display("FAIL reset_addr: got %0d want 0", addr_a); end
        checks++; if (wdata_a !== 8'd0) begin errors++; $display("FAIL reset_wdata: got %0d want 0", wdata_a); end
    endtask

    task automatic test_alternating();
        int cyc, bcyc;
        logic d0;
        logic [7:0] exp [3];
        exp = '{8'd64, 8'd32, 8'd126};
        fill_a(8'hA8, 8'h55);
        do_run(1'b0, -1, cyc, bcyc, d0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem_a[33+i] !== exp[i]) begin
                errors++; $display("FAIL alt_res%0d: got %0d want %0d", i, mem_a[33+i], exp[i]);
            end
        end
        checks++; if (cyc !== 36)  begin errors++; $display("FAIL alt_latency: got %0d want 36", cyc); end
        checks++; if (bcyc !== 36) begin errors++; $display("FAIL alt_busy_span: got %0d want 36", bcyc); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL alt_busy_done: got %b want 0", busy_a); end
    endtask

    task automatic test_uniform();
        int cyc, bcyc;
        logic d0;
        logic [7:0] exp [3];
        exp = '{8'd128, 8'd32, 8'd252};
        fill_a(8'h00, 8'h00);
        do_run(1'b0, -1, cyc, bcyc, d0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem_a[33+i] !== exp[i]) begin
                errors++; $display("FAIL zeros_res%0d: got %0d want %0d", i, mem_a[33+i], exp[i]);
            end
        end
        for (int i = 33; i < 36; i++) mem_a[i] = 8'h00;
        fill_a(8'hF8, 8'hFF);
        do_run(1'b0, -1, cyc, bcyc, d0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem_a[33+i] !== exp[i]) begin
                errors++; $display("FAIL ones_res%0d: got %0d want %0d", i, mem_a[33+i], exp[i]);
            end
        end
    endtask

    task automatic test_crossing();
        int cyc, bcyc;
        logic d0;
        logic [7:0] exp [3];
        fill_a(8'hF8, 8'h00);
        mem_a[0] = 8'h03;
        mem_a[1] = 8'hE0;
        exp = '{8'd0, 8'd0, 8'd1};
        do_run(1'b0, -1, cyc, bcyc, d0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem_a[33+i] !== exp[i]) begin
                errors++; $display("FAIL cross_res%0d: got %0d want %0d", i, mem_a[33+i], exp[i]);
            end
        end
        fill_a(8'hF8, 8'h00);
        mem_a[0] = 8'hF8;
        exp = '{8'd1, 8'd1, 8'd1};
        do_run(1'b0, -1, cyc, bcyc, d0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem_a[33+i] !== exp[i]) begin
                errors++; $display("FAIL head_res%0d: got %0d want %0d", i, mem_a[33+i], exp[i]);
            end
        end
    endtask

    task automatic test_saturate();
        int cyc, bcyc;
        logic d0;
        logic [7:0] exp [3];
        exp = '{8'd255, 8'd64, 8'd255};
        for (int i = 0; i < 65; i++) mem_b[i] = 8'h00;
        do_run(1'b1, -1, cyc, bcyc, d0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem_b[65+i] !== exp[i]) begin
                errors++; $display("FAIL sat_res%0d: got %0d want %0d", i, mem_b[65+i], exp[i]);
            end
        end
        checks++; if (cyc !== 68) begin errors++; $display("FAIL sat_latency: got %0d want 68", cyc); end
    endtask

    task automatic test_reset_mid_scan();
        int cyc, bcyc;
        logic d0;
        logic [7:0] sent [3];
        logic [7:0] exp [3];
        sent = '{8'hA5, 8'h5A, 8'hC3};
        exp  = '{8'd64, 8'd32, 8'd126};
        fill_a(8'hA8, 8'h55);
        for (int i = 0; i < 3; i++) mem_a[33+i] = sent[i];
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        checks++; if (addr_a !== 8'd10) begin errors++; $display("FAIL mid_addr: got %0d want 10", addr_a); end
        checks++; if (busy_a !== 1'b1)  begin errors++; $display("FAIL mid_busy: got %b want 1", busy_a); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done_a); end
        checks++; if (we_a !== 1'b0)   begin errors++; $display("FAIL rst_we: got %b want 0", we_a); end
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem_a[33+i] !== sent[i]) begin
                errors++; $display("FAIL rst_keep%0d: got %0h want %0h", i, mem_a[33+i], sent[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        do_run(1'b0, -1, cyc, bcyc, d0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem_a[33+i] !== exp[i]) begin
                errors++; $display("FAIL post_rst_res%0d: got %0d want %0d", i, mem_a[33+i], exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bcyc;
        logic d0;
        logic [7:0] exp [3];
        exp = '{8'd64, 8'd32, 8'd126};
        fill_a(8'hA8, 8'h55);
        for (int i = 33; i < 36; i++) mem_a[i] = 8'h00;
        do_run(1'b0, 5, cyc, bcyc, d0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem_a[33+i] !== exp[i]) begin
                errors++; $display("FAIL ign_res%0d: got %0d want %0d", i, mem_a[33+i], exp[i]);
            end
        end
        checks++; if (cyc !== 36) begin errors++; $display("FAIL ign_latency: got %0d want 36", cyc); end
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL done_held: got %b want 1", done_a); end
        exp = '{8'd128, 8'd32, 8'd252};
        fill_a(8'h00, 8'h00);
        do_run(1'b0, -1, cyc, bcyc, d0);
        checks++; if (d0 !== 1'b0) begin errors++; $display("FAIL rerun_done_drop: got %b want 0", d0); end
        checks++; if (cyc !== 36)  begin errors++; $display("FAIL rerun_latency: got %0d want 36", cyc); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem_a[33+i] !== exp[i]) begin
                errors++; $display("FAIL rerun_res%0d: got %0d want %0d", i, mem_a[33+i], exp[i]);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        #12;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_alternating();
        test_uniform();
        test_crossing();
        test_saturate();
        test_reset_mid_scan();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pattern_scan_engine.md
Name: pattern_scan_engine

Overview:
- Hardware accelerator for the bit-pattern counting task: on start, reads a PAT_W-bit pattern and a MSG_BYTES-byte message from data memory.
- Computes three counts and writes them back to memory:
  - matches inside bytes
  - bytes with at least one match
  - matches across the whole bit string, including byte-crossing windows
- Generalises the fixed 5-bit/32-byte case in pattern width, message length and counter width.
- Adds saturating counts and a busy/done handshake.
- Sits beside data memory in the top level and shares its single read/write port.

Parameters:
- PAT_W, 5, pattern width in bits; legal 2..8.
- MSG_BYTES, 32, message length in bytes; legal 1..(2**ADDR_W - 4).
- ADDR_W, 8, data-memory address width.
- CNT_W, 8, result counter width; each result byte is the low 8 bits of a saturated count.
- MSG_BASE, 0, address of message byte 0.
- PAT_ADDR, 32, address of the pattern byte; the pattern is bits [7:8-PAT_W].
- RES_ADDR, 33, first result address; results go to RES_ADDR (ctb), RES_ADDR+1 (cto), RES_ADDR+2 (cts).

Ports:
- CLK  in  1  clock.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to run.
- mem_addr  out  ADDR_W  data-memory address.
- mem_rdata  in  8  data-memory read data; combinational (asynchronous) read of mem_addr.
- mem_wdata  out  8  write data.
- mem_we  out  1  write enable; the write commits on the CLK rising edge.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  high in DONE; held until the next accepted start.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Counters, pattern register and previous-byte register are cleared.
  - Reset mid-run abandons the run with no further writes; an already-committed write stays.
- States: IDLE -> LD_PAT -> SCAN -> WR_CTB -> WR_CTO -> WR_CTS -> DONE.
  - IDLE/DONE: if start then go to LD_PAT, clear counters, done=0. start is ignored in every other state.
  - LD_PAT: mem_addr=PAT_ADDR; latch pat=mem_rdata[7:8-PAT_W]; idx=0; go to SCAN.
  - SCAN: mem_addr=MSG_BASE+idx; evaluate byte b=mem_rdata.
    - Within-byte windows b[k+PAT_W-1:k] for k=0..8-PAT_W: add the number of matches m to ctb and to cts; if m>0, cto+=1.
    - Crossing windows, only when idx>0: the (PAT_W-1) windows of {prev[PAT_W-2:0], b} spanning the boundary; add matches to cts.
    - Then prev=b, idx+=1. After idx=MSG_BYTES-1, go to WR_CTB.
  - WR_CTB / WR_CTO / WR_CTS: mem_we=1, mem_addr=RES_ADDR+0/1/2, mem_wdata=ctb/cto/cts low byte; one cycle each.
  - DONE: done=1, busy=0.
- String order: byte 0 is first; bit 7 of each byte is its first bit.
- Arithmetic: all counters are CNT_W bits and saturate at 2**CNT_W-1. Per-byte increments are computed at full width before the saturating add.
- Latency: start accepted at edge 0; done rises after 1+MSG_BYTES+3 further cycles; busy is high for exactly that span.
- mem_we is high only in WR_* states.

Decomposition:
- Package pse_pkg:
  - state enum {IDLE, LD_PAT, SCAN, WR_CTB, WR_CTO, WR_CTS, DONE}.
  - Default address constants.
  - A localparam function giving the windows per byte (9-PAT_W).
- Sub-module window_match_unit (combinational, parametrised by PAT_W):
  - Inputs: prev, cur, pat, first.
  - Outputs: in_cnt (within-byte matches), cross_cnt (boundary matches, 0 when first), any_in.
- The FSM, counters and memory muxing stay in pattern_scan_engine.

Test Plan:
- Defaults; pat=5'b10101; all 32 bytes 8'h55 -> mem[33]=64, mem[34]=32, mem[35]=126; done after 36 cycles.
- pat=5'b00000; all bytes 8'h00 -> 128, 32, 252; repeat with pat=5'b11111 and bytes 8'hFF -> 128, 32, 252.
- pat=5'b11111; byte0=8'h03, byte1=8'hE0, rest 0 -> 0, 0, 1 (crossing-only match); second case byte0=8'hF8, rest 0 -> 1, 1, 1.
- MSG_BYTES=64, CNT_W=8; all bytes 0; pat=0 -> ctb saturates 255, cto=64, cts=255.
- Reset asserted mid-SCAN (idx=10):
  - Immediately busy=0, done=0, mem_we=0; locations 33..35 unchanged.
  - A new start yields correct results.
- start pulsed during SCAN is ignored (same results and latency); start in DONE reruns; done drops the cycle after start.
